bcd_modn_counter: RTL and testbench

BCD_MODN_COUNTER -- requirements
Module: bcd_modn_counter

---
 rtl/bcd_modn_counter.sv | 114 +++++++++++
 tb/tb_bcd_modn_counter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/bcd_modn_counter.sv
// Parameterized multi-digit BCD up/down counter with a [MIN_VAL, MAX_VAL] range,
// validated synchronous load, a combinational cascade terminal count and registered wrap/error pulses.

module bcd_digit_step (
  input  logic [3:0] dig,
  input  logic       up,
  input  logic       cin,
  output logic [3:0] nxt
);
  always_comb begin
    nxt = dig;
    if (cin) begin
      if (up) nxt = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
      else    nxt = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
    end
  end
endmodule

module bcd_modn_counter #(
  parameter int DIGITS  = 2,
  parameter int MIN_VAL = 0,
  parameter int MAX_VAL = 59
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ena,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] d,
  output logic [4*DIGITS-1:0] q,
  output logic                tc,
  output logic                co,
  output logic                load_err
);
  localparam int W = 4*DIGITS;

  if (DIGITS < 1 || DIGITS > 4 || MIN_VAL < 0 || MIN_VAL >= MAX_VAL ||
      MAX_VAL > 10**DIGITS - 1) begin : g_param_err
    $error("bcd_modn_counter: illegal DIGITS/MIN_VAL/MAX_VAL combination");
  end

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);

  logic              at_min, at_max;
  logic [DIGITS-1:0] cin;
  logic [W-1:0]      q_step;
  int                d_val;
  logic              d_digs_ok, d_ok;

  assign at_min = (q == MIN_BCD);
  assign at_max = (q == MAX_BCD);
  assign tc     = ena & (up ? at_max : at_min);

  // A digit steps only when every lower digit is at its rollover edge (9 up, 0 down).
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    if (i == 0) begin : g_lsd
      assign cin[i] = 1'b1;
    end else begin : g_upper
      assign cin[i] = cin[i-1] & (up ? (q[4*(i-1) +: 4] == 4'd9)
                                     : (q[4*(i-1) +: 4] == 4'd0));
    end
    bcd_digit_step u_step (
      .dig (q[4*i +: 4]),
      .up  (up),
      .cin (cin[i]),
      .nxt (q_step[4*i +: 4])
    );
  end

  always_comb begin
    d_val     = 0;
    d_digs_ok = 1'b1;
    for (int i = DIGITS-1; i >= 0; i--) begin
      d_val = d_val*10 + int'(d[4*i +: 4]);
      if (d[4*i +: 4] > 4'd9) d_digs_ok = 1'b0;
    end
    d_ok = d_digs_ok && (d_val >= MIN_VAL) && (d_val <= MAX_VAL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q        <= MIN_BCD;
      co       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      co       <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (d_ok) q <= d;
        else      load_err <= 1'b1;
      end else if (ena) begin
        if (up ? at_max : at_min) begin
          q  <= up ? MIN_BCD : MAX_BCD;
          co <= 1'b1;
        end else begin
          q  <= q_step;
        end
      end
    end
  end
endmodule

// File: tb/tb_bcd_modn_counter.sv
// Directed bench: default 00..59 counter, a 01..12 counter, and a two-stage tc cascade.

module tb_bcd_modn_counter;
  logic clk;
  int   checks = 0;
  int   errors = 0;

  logic       a_reset, a_ena, a_up, a_load;
  logic [7:0] a_d, a_q;
  logic       a_tc, a_co, a_err;

  logic       b_reset, b_ena, b_up, b_load;
  logic [7:0] b_d, b_q;
  logic       b_tc, b_co, b_err;

  logic       c_reset, c_ena, c_up;
  logic [7:0] lo_q, hi_q;
  logic       lo_tc, lo_co, lo_err, hi_tc, hi_co, hi_err;

  bcd_modn_counter u_a (
    .clk(clk), .reset(a_reset), .ena(a_ena), .up(a_up), .load(a_load), .d(a_d),
    .q(a_q), .tc(a_tc), .co(a_co), .load_err(a_err));

  bcd_modn_counter #(.DIGITS(2), .MIN_VAL(1), .MAX_VAL(12)) u_b (
    .clk(clk), .reset(b_reset), .ena(b_ena), .up(b_up), .load(b_load), .d(b_d),
    .q(b_q), .tc(b_tc), .co(b_co), .load_err(b_err));

  bcd_modn_counter u_lo (
    .clk(clk), .reset(c_reset), .ena(c_ena), .up(c_up), .load(1'b0), .d(8'h00),
    .q(lo_q), .tc(lo_tc), .co(lo_co), .load_err(lo_err));

  bcd_modn_counter u_hi (
    .clk(clk), .reset(c_reset), .ena(lo_tc), .up(c_up), .load(1'b0), .d(8'h00),
    .q(hi_q), .tc(hi_tc), .co(hi_co), .load_err(hi_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    int m, lo_m, hi_m;
    a_reset = 1; a_ena = 0; a_up = 1; a_load = 0; a_d = 8'h00;
    b_reset = 1; b_ena = 0; b_up = 1; b_load = 0; b_d = 8'h00;
    c_reset = 1; c_ena = 0; c_up = 1;

    // reset state
    step();
    chk("a_reset_q", a_q, 8'h00);
    chk("a_reset_co", a_co, 0);
    chk("a_reset_err", a_err, 0);

    // full up sweep 00..59 -> 00
    a_reset = 0; a_ena = 1; a_up = 1;
    m = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      chk("a_sweep_tc", a_tc, (m == 59));
      step();
      chk("a_sweep_co", a_co, (m == 59));
      m = (m == 59) ? 0 : m + 1;
      chk("a_sweep_q", a_q, bcd2(m));
    end
    chk("a_sweep_end", a_q, 8'h00);

    // digit carry/borrow and direction changes
    a_ena = 0; a_load = 1; a_d = 8'h09; step();
    chk("a_load09", a_q, 8'h09);
    chk("a_load09_err", a_err, 0);
    a_load = 0; a_ena = 1; a_up = 1; step();
    chk("a_09_up", a_q, 8'h10);
    a_up = 0; step();
    chk("a_10_dn", a_q, 8'h09);
    a_ena = 0; a_load = 1; a_d = 8'h00; step();
    a_load = 0; a_ena = 1; a_up = 0;
    #1;
    chk("a_tc_min_dn", a_tc, 1);
    a_ena = 0;
    #1;
    chk("a_tc_noena", a_tc, 0);
    a_ena = 1; step();
    chk("a_00_dn", a_q, 8'h59);
    chk("a_00_dn_co", a_co, 1);
    step();
    chk("a_59_dn", a_q, 8'h58);
    chk("a_59_dn_co", a_co, 0);

    // rejected and accepted loads
    a_ena = 0; a_load = 1; a_d = 8'h3A; step();
    chk("a_ld3A_q", a_q, 8'h58);
    chk("a_ld3A_err", a_err, 1);
    a_load = 0; step();
    chk("a_ld3A_err_clr", a_err, 0);
    chk("a_hold_q", a_q, 8'h58);
    a_load = 1; a_d = 8'h60; step();
    chk("a_ld60_q", a_q, 8'h58);
    chk("a_ld60_err", a_err, 1);
    a_ena = 1; a_up = 1; a_d = 8'h45; step();
    chk("a_ld45_q", a_q, 8'h45);
    chk("a_ld45_err", a_err, 0);
    a_d = 8'h59; step();
    chk("a_ld59_q", a_q, 8'h59);

    // reset on the wrap cycle, and reset over load+ena
    a_load = 0; a_ena = 1; a_up = 1; a_reset = 1; step();
    chk("a_rst_wrap_q", a_q, 8'h00);
    chk("a_rst_wrap_co", a_co, 0);
    a_load = 1; a_d = 8'h45; step();
    chk("a_rst_pri_q", a_q, 8'h00);
    chk("a_rst_pri_err", a_err, 0);
    a_reset = 0; a_load = 0; step();
    chk("a_resume_q", a_q, 8'h01);

    // 01..12 counter
    b_reset = 1; step();
    chk("b_reset_q", b_q, 8'h01);
    b_reset = 0; b_load = 1; b_d = 8'h12; step();
    chk("b_ld12", b_q, 8'h12);
    b_load = 0; b_ena = 1; b_up = 1; step();
    chk("b_up_wrap_q", b_q, 8'h01);
    chk("b_up_wrap_co", b_co, 1);
    b_up = 0; step();
    chk("b_dn_wrap_q", b_q, 8'h12);
    chk("b_dn_wrap_co", b_co, 1);
    step();
    chk("b_dn_q", b_q, 8'h11);
    chk("b_dn_co", b_co, 0);
    b_ena = 0; b_load = 1; b_d = 8'h00; step();
    chk("b_ld00_q", b_q, 8'h11);
    chk("b_ld00_err", b_err, 1);
    b_d = 8'h13; step();
    chk("b_ld13_err", b_err, 1);
    b_load = 0; step();
    chk("b_err_clr", b_err, 0);

    // cascade 0000..5959 -> 0000
    step();
    c_reset = 0; c_ena = 1; c_up = 1;
    lo_m = 0; hi_m = 0;
    chk("c_start", {hi_q, lo_q}, 16'h0000);
    for (int k = 0; k < 3600; k++) begin
      step();
      if (lo_m == 59) begin
        lo_m = 0;
        hi_m = (hi_m == 59) ? 0 : hi_m + 1;
      end else begin
        lo_m++;
      end
      chk("c_cascade", {hi_q, lo_q}, {bcd2(hi_m), bcd2(lo_m)});
    end
    chk("c_end", {hi_q, lo_q}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
